array_scan_reader: RTL and testbench
====================================

# array_scan_reader

Sequential reader for a small register array (DEPTH × WIDTH). A side port writes the array. On `start`, the block walks indices from `lo` while `(i <= hi) && (i < DEPTH)` holds, and streams each entry out over a valid/ready handshake. If the loop condition is false at entry, the scan has zero trips: no beats are produced, only `done`. It sits opposite the array writer and drains or inspects the array contents for downstream checkers.

## Interface
- `WIDTH`, 4, data bits per entry
- `DEPTH`, 4, number of entries; must be ≥ 2
- `AW`, `$clog2(DEPTH)`, index width; derived, not overridden
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  write strobe for the array
- `wr_addr`  in  AW  write index
- `wr_data`  in  WIDTH  write data
- `start`  in  1  scan request; sampled only in IDLE
- `lo`  in  AW+1  first index; sampled with `start`
- `hi`  in  AW+1  last index, inclusive; sampled with `start`
- `busy`  out  1  high in RUN and HOLD
- `out_valid`  out  1  beat available
- `out_ready`  in  1  consumer accepts the beat
- `out_addr`  out  AW  index of the current beat
- `out_data`  out  WIDTH  entry value for the current beat
- `out_last`  out  1  current beat is the final one of the scan
- `done`  out  1  one-cycle pulse when the scan ends

## Operation
- **Reset:** all array entries are 0, the state is IDLE, and every output is 0.
- **States:** IDLE, RUN, HOLD, DONE.
- **IDLE:**
  - On `start`, latch `lo` and `hi` and set `i = lo`.
  - If `(lo <= hi) && (lo < DEPTH)`, go to RUN. Otherwise go to DONE (zero-trip).
- **RUN:**
  - Load the beat: `out_addr = i`, `out_data = mem[i]`, `out_valid = 1`.
  - `out_last = 1` when `i == min(hi, DEPTH-1)`.
  - Go to HOLD.
- **HOLD:**
  - Hold the beat stable while `out_valid && !out_ready`.
  - On handshake, if `out_last`, go to DONE. Otherwise set `i = i + 1` and go to RUN.
- **DONE:** assert `done` for one cycle, then return to IDLE.
- **Width rule:** `lo`, `hi` and `i` are AW+1 bits, so `hi >= DEPTH` clamps to DEPTH-1 with no wrap. `i` never exceeds DEPTH-1.
- **Writes:** accepted in every state.
  - A write to index i in the same cycle the beat is loaded does not affect that beat; the beat carries the pre-write value.
  - Later beats see every write completed before they are loaded.
- **Start while busy or in DONE:** ignored.
- **Reset mid-scan:** the scan aborts immediately, the array clears to 0, and `done` is not pulsed.

## Timing
- `start` at cycle 0: first `out_valid` at cycle 1.
- Each beat occupies a minimum of 2 cycles (RUN, then HOLD with `out_ready` high), so peak throughput is 1 beat / 2 cycles.
- `done` fires the cycle after the last handshake.
- Zero-trip scan: `done` at cycle 1, with no `out_valid`.
- `out_addr`, `out_data` and `out_last` are registered and stable while `out_valid && !out_ready`.
- `out_valid` never drops without a handshake, except under reset.

## Configuration
- **`ARRAY_SCAN_SKIP_ZERO_EN` defined:**
  - In RUN, an index whose entry equals 0 produces no beat; `i` advances and RUN repeats, costing one cycle per skipped entry.
  - `out_last` is set when no nonzero entry exists in `(i, min(hi, DEPTH-1)]`. This lookahead is evaluated in the load cycle.
  - A skipped entry that ends the range goes to DONE.
  - If all entries in range are 0, there are no beats, and `done` fires 1 cycle after the last skipped index.
- **Undefined:** every index in range produces a beat, including zero-valued entries.

## Test plan
- **Zero-trip:** `start` with `lo=2`, `hi=1` -> `done` at cycle 1, no `out_valid`, `busy` stays 0.
- **Full scan:** write mem = {0,0,2,3}, then `start` with `lo=0`, `hi=3`, `out_ready=1` -> beats (0,0), (1,0), (2,2), (3,3) on cycles 1, 3, 5, 7; `out_last` on addr 3; `done` at cycle 8.
  - With `ARRAY_SCAN_SKIP_ZERO_EN`: beats (2,2) and (3,3) only, with `out_last` on addr 3.
- **Clamp:** `lo=2`, `hi=7` -> beats at addr 2 and 3, `out_last` on addr 3, no access beyond DEPTH-1.
- **Backpressure:** hold `out_ready=0` for 5 cycles on beat addr 1 -> `out_addr`, `out_data` and `out_last` stay constant; the next beat follows the handshake by 2 cycles.
- **Write collision:** write mem[2]=4'hA in the cycle the addr-2 beat loads -> beat carries 2. A second scan returns 4'hA.
- **Reset mid-scan:** assert `rst_n=0` during HOLD -> all outputs are 0 at once, with no `done`. After release, a scan `lo=0`, `hi=3` returns four beats of 0.

Source files
------------

// File: rtl/array_scan_reader.sv
// array_scan_reader: DEPTH x WIDTH register array with a side write port and a scanner that streams
// entries lo..min(hi,DEPTH-1) over valid/ready. Optional build macro: ARRAY_SCAN_SKIP_ZERO_EN.
module array_scan_reader #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic [AW:0]      lo,
  input  logic [AW:0]      hi,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_addr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  localparam logic [AW:0] TOP_IDX   = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] DEPTH_IDX = (AW+1)'(DEPTH);

  state_t           state_q;
  logic [AW:0]      i_q;
  logic [AW:0]      hi_q;
  logic             busy_q;
  logic             out_valid_q;
  logic [AW-1:0]    out_addr_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_last_q;
  logic             done_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (wr_en && (wr_addr == AW'(k))) mem_q[k] <= wr_data;
      end
    end
  end

  // In IDLE the bounds come straight from the request, so the first beat loads on the start edge.
  logic [AW:0]      cur_i;
  logic [AW:0]      cur_hi;
  logic [AW:0]      last_idx;
  logic [WIDTH-1:0] cur_data;
  logic             entry_ok;
  logic             do_load;
  logic             skip_cur;
  logic             beat_last;

  always_comb begin
    cur_i    = (state_q == IDLE) ? lo : i_q;
    cur_hi   = (state_q == IDLE) ? hi : hi_q;
    last_idx = (cur_hi > TOP_IDX) ? TOP_IDX : cur_hi;
    cur_data = mem_q[cur_i[AW-1:0]];
    entry_ok = (lo <= hi) && (lo < DEPTH_IDX);
    do_load  = (state_q == RUN) || ((state_q == IDLE) && start && entry_ok);
  end

`ifdef ARRAY_SCAN_SKIP_ZERO_EN
  logic [DEPTH-1:0] nz_after;
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_nz
    localparam logic [AW:0] IDX = (AW+1)'(gi);
    assign nz_after[gi] = (IDX > cur_i) && (IDX <= last_idx) && (mem_q[gi] != '0);
  end
  assign skip_cur  = (cur_data == '0);
  assign beat_last = ~|nz_after;
`else
  assign skip_cur  = 1'b0;
  assign beat_last = (cur_i == last_idx);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      i_q         <= '0;
      hi_q        <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            hi_q <= hi;
            i_q  <= lo;
            if (!entry_ok) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              i_q     <= i_q + 1'b1;
              state_q <= RUN;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: ;
      endcase

      if (do_load) begin
        if (skip_cur) begin
          if (cur_i == last_idx) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            i_q     <= cur_i + 1'b1;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end else begin
          i_q         <= cur_i;
          out_valid_q <= 1'b1;
          out_addr_q  <= cur_i[AW-1:0];
          out_data_q  <= cur_data;
          out_last_q  <= beat_last;
          state_q     <= HOLD;
          busy_q      <= 1'b1;
        end
      end
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_array_scan_reader.sv
// Bench for array_scan_reader: directed plan steps, then randomized scans checked against a
// queue model built from the scan rules (index range, clamp, last flag, beat/done timing).
`timescale 1ns/1ps
module tb_array_scan_reader;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic [AW:0]      lo;
  logic [AW:0]      hi;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [AW-1:0]    out_addr;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             done;

  array_scan_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .lo(lo), .hi(hi), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] ref_mem [DEPTH];

  typedef struct { int addr; int data; int last; } beat_t;
  beat_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = WIDTH'(d);
    step();
    wr_en = 1'b0;
    ref_mem[a] = WIDTH'(d);
  endtask

  // mode 0: ready always high; 1: random ready plus start noise; 2: stall addr 1 for 5 cycles
  task automatic run_scan(input string name, input int lo_v, input int hi_v, input int mode,
                          input int coll_cycle, input int coll_addr, input int coll_data);
    int n, c, last_hs, beats, stall, lastix;
    bit prev_hold, saw_done, r;
    logic [AW-1:0] pa;
    logic [WIDTH-1:0] pd;
    logic pl;
    beat_t b, e;
    exp_q.delete();
    lastix = (hi_v > DEPTH - 1) ? DEPTH - 1 : hi_v;
    for (int i = lo_v; (i <= hi_v) && (i < DEPTH); i++) begin
      b.addr = i; b.data = int'(ref_mem[i]); b.last = (i == lastix) ? 1 : 0;
      exp_q.push_back(b);
    end
    n = exp_q.size();
    start = 1'b1; lo = (AW+1)'(lo_v); hi = (AW+1)'(hi_v); out_ready = 1'b0;
    step();
    start = 1'b0;
    c = 1; last_hs = 0; beats = 0; stall = 0; prev_hold = 0; saw_done = 0;
    pa = '0; pd = '0; pl = 1'b0;
    while (!saw_done && c < 200) begin
      if (c == coll_cycle) begin
        wr_en = 1'b1; wr_addr = AW'(coll_addr); wr_data = WIDTH'(coll_data);
      end else begin
        wr_en = 1'b0;
      end
      if (prev_hold) begin
        chk({name, ":hold_valid"}, 32'(out_valid), 32'd1);
        chk({name, ":hold_addr"}, 32'(out_addr), 32'(pa));
        chk({name, ":hold_data"}, 32'(out_data), 32'(pd));
        chk({name, ":hold_last"}, 32'(out_last), 32'(pl));
      end else if (out_valid) begin
        chk({name, ":beat_cycle"}, 32'(c), 32'((beats == 0) ? 1 : last_hs + 2));
        if (exp_q.size() == 0) begin
          chk({name, ":extra_beat"}, 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk({name, ":addr"}, 32'(out_addr), 32'(e.addr));
          chk({name, ":data"}, 32'(out_data), 32'(e.data));
          chk({name, ":last"}, 32'(out_last), 32'(e.last));
        end
      end
      if (out_valid) begin
        chk({name, ":busy_beat"}, 32'(busy), 32'd1);
        case (mode)
          0:       r = 1'b1;
          1:       r = ($urandom_range(0, 3) != 0);
          default: r = !((out_addr == AW'(1)) && (stall < 5));
        endcase
        if (!r && mode == 2) stall++;
        out_ready = r;
        if (r) begin
          last_hs = c; beats++; prev_hold = 0;
        end else begin
          prev_hold = 1; pa = out_addr; pd = out_data; pl = out_last;
        end
      end else begin
        out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (n == 0) chk({name, ":busy_zero"}, 32'(busy), 32'd0);
      if (done) begin
        saw_done = 1;
        chk({name, ":done_cycle"}, 32'(c), 32'((n == 0) ? 1 : last_hs + 1));
        chk({name, ":beat_count"}, 32'(beats), 32'(n));
        chk({name, ":busy_done"}, 32'(busy), 32'd0);
        start = 1'b0;
      end else if (mode == 1) begin
        start = 1'($urandom_range(0, 1));
        lo = (AW+1)'($urandom);
        hi = (AW+1)'($urandom);
      end
      if (!saw_done) begin
        step();
        c++;
      end
    end
    if (!saw_done) chk({name, ":timeout"}, 32'd0, 32'd1);
    start = 1'b0; wr_en = 1'b0; out_ready = 1'b0;
    step();
    chk({name, ":done_pulse"}, 32'(done), 32'd0);
    if (coll_cycle > 0) ref_mem[coll_addr] = WIDTH'(coll_data);
    $display("scan %s lo=%0d hi=%0d beats=%0d expected=%0d cycles=%0d", name, lo_v, hi_v, beats, n, c);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; lo = '0; hi = '0; out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
    step();
    step();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_addr", 32'(out_addr), 32'd0);
    chk("reset_data", 32'(out_data), 32'd0);
    chk("reset_last", 32'(out_last), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    step();

    run_scan("zero_trip", 2, 1, 0, 0, 0, 0);
    do_write(2, 2);
    do_write(3, 3);
    run_scan("full", 0, 3, 0, 0, 0, 0);
    run_scan("clamp", 2, 7, 0, 0, 0, 0);
    run_scan("lo_beyond", 5, 7, 0, 0, 0, 0);
    run_scan("backpressure", 0, 3, 2, 0, 0, 0);
    run_scan("collision", 0, 3, 0, 4, 2, 10);
    run_scan("collision2", 0, 3, 0, 0, 0, 0);

    start = 1'b1; lo = 3'd0; hi = 3'd3; out_ready = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    chk("mid_rst_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_addr", 32'(out_addr), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    step();
    chk("mid_rst_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
    step();
    chk("post_rst_no_done", 32'(done), 32'd0);
    run_scan("after_reset", 0, 3, 0, 0, 0, 0);

    for (int t = 0; t < 16; t++) begin
      do_write($urandom_range(0, DEPTH - 1), $urandom_range(0, 15));
      do_write($urandom_range(0, DEPTH - 1), $urandom_range(0, 15));
      run_scan("random", $urandom_range(0, 7), $urandom_range(0, 7), 1, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
